// File: rtl/cal_core_sched.sv
// cal_core_sched: fetches one H/y row and its alpha columns per run step,
// streams them to the detector core and collects one beta result per row.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 run request (IDLE only)
//   h_mem_addr            H/y memory row address (= row_cnt)
//   h_mem_data/y_mem_data H row / y word, 1-cycle read latency
//   alpha_mem_addr/_data  alpha column address / data, 1-cycle latency
//   H_row,y,*_tvalid      row load to the core
//   alpha_u_col*          alpha column stream to the core
//   beta, beta_tvalid     result from the core
//   beta_out*             result tagged with its row index
//   busy, done,
//   timeout_err           status
module cal_core_sched #(
    parameter int J       = 4,
    parameter int I       = 8,
    parameter int A       = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [$clog2(I)-1:0]  h_mem_addr,
    input  logic [J*64-1:0]       h_mem_data,
    input  logic [127:0]          y_mem_data,
    output logic [$clog2(I*A)-1:0] alpha_mem_addr,
    input  logic [J*8-1:0]        alpha_mem_data,
    output logic [J*64-1:0]       H_row,
    output logic                  H_row_tvalid,
    output logic [127:0]          y,
    output logic                  y_tvalid,
    output logic [J*8-1:0]        alpha_u_col,
    output logic                  alpha_u_col_tvalid,
    output logic                  alpha_u_col_tlast,
    input  logic [A*8-1:0]        beta,
    input  logic                  beta_tvalid,
    output logic [A*8-1:0]        beta_out,
    output logic                  beta_out_tvalid,
    output logic [$clog2(I)-1:0]  beta_out_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    localparam int RW = $clog2(I);
    localparam int AW = $clog2(I*A);
    localparam int CW = $clog2(A+1);
    localparam int TW = $clog2(TIMEOUT+1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_HY,
        S_LOAD_HY,
        S_STREAM,
        S_WAIT_BETA,
        S_FIN
    } state_t;

    state_t          r_state;
    logic [RW-1:0]   r_row_cnt;
    logic [CW-1:0]   r_col_cnt;
    logic [TW-1:0]   r_wait_cnt;
    logic            r_rd_vld;
    logic            r_rd_last;
    logic [J*64-1:0] r_h_row;
    logic [127:0]    r_y;
    logic            r_hy_vld;
    logic [J*8-1:0]  r_alpha;
    logic            r_alpha_vld;
    logic            r_alpha_last;
    logic [A*8-1:0]  r_beta;
    logic            r_beta_vld;
    logic [RW-1:0]   r_beta_idx;
    logic            r_busy;
    logic            r_done;
    logic            r_tmo;

    logic            w_issue;
    logic            w_issue_last;
    logic [AW-1:0]   w_alpha_addr;

    // Column reads are issued while col_cnt < A; STREAM then lingers
    // until the last registered beat has been presented to the core.
    assign w_issue      = (r_state == S_STREAM) && (r_col_cnt < CW'(A));
    assign w_issue_last = w_issue && (r_col_cnt == CW'(A-1));
    assign w_alpha_addr = AW'(r_row_cnt) * AW'(A) + AW'(r_col_cnt);

    assign h_mem_addr     = r_row_cnt;
    assign alpha_mem_addr = w_issue ? w_alpha_addr : '0;

    assign H_row              = r_h_row;
    assign H_row_tvalid       = r_hy_vld;
    assign y                  = r_y;
    assign y_tvalid           = r_hy_vld;
    assign alpha_u_col        = r_alpha;
    assign alpha_u_col_tvalid = r_alpha_vld;
    assign alpha_u_col_tlast  = r_alpha_last;
    assign beta_out           = r_beta;
    assign beta_out_tvalid    = r_beta_vld;
    assign beta_out_idx       = r_beta_idx;
    assign busy               = r_busy;
    assign done               = r_done;
    assign timeout_err        = r_tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_row_cnt    <= '0;
            r_col_cnt    <= '0;
            r_wait_cnt   <= '0;
            r_rd_vld     <= 1'b0;
            r_rd_last    <= 1'b0;
            r_h_row      <= '0;
            r_y          <= '0;
            r_hy_vld     <= 1'b0;
            r_alpha      <= '0;
            r_alpha_vld  <= 1'b0;
            r_alpha_last <= 1'b0;
            r_beta       <= '0;
            r_beta_vld   <= 1'b0;
            r_beta_idx   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_tmo        <= 1'b0;
        end else begin
            // single-cycle pulses default low
            r_hy_vld   <= 1'b0;
            r_beta_vld <= 1'b0;
            r_done     <= 1'b0;

            // alpha read pipeline: address cycle -> data cycle -> beat
            r_rd_vld     <= w_issue;
            r_rd_last    <= w_issue_last;
            r_alpha_vld  <= r_rd_vld;
            r_alpha_last <= r_rd_last;
            if (r_rd_vld) begin
                r_alpha <= alpha_mem_data;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row_cnt <= '0;
                        r_tmo     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RD_HY;
                    end
                end
                S_RD_HY: begin
                    r_state <= S_LOAD_HY;
                end
                S_LOAD_HY: begin
                    r_h_row   <= h_mem_data;
                    r_y       <= y_mem_data;
                    r_hy_vld  <= 1'b1;
                    r_col_cnt <= '0;
                    r_state   <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_issue) begin
                        r_col_cnt <= r_col_cnt + CW'(1);
                    end
                    if (r_alpha_vld && r_alpha_last) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT_BETA;
                    end
                end
                S_WAIT_BETA: begin
                    // a beta arriving on the timeout cycle still wins
                    if (beta_tvalid) begin
                        r_beta     <= beta;
                        r_beta_vld <= 1'b1;
                        r_beta_idx <= r_row_cnt;
                        if (r_row_cnt == RW'(I-1)) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_row_cnt <= r_row_cnt + RW'(1);
                            r_state   <= S_RD_HY;
                        end
                    end else if (r_wait_cnt == TW'(TIMEOUT)) begin
                        r_tmo   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cal_core_sched.sv
// tb_cal_core_sched: directed bench for cal_core_sched with memory
// models and a hand-driven core beta response.
module tb_cal_core_sched;

    localparam int J  = 4;
    localparam int I  = 8;
    localparam int A  = 4;
    localparam int TO = 16;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2:0]     h_mem_addr;
    logic [255:0]   h_mem_data;
    logic [127:0]   y_mem_data;
    logic [4:0]     alpha_mem_addr;
    logic [31:0]    alpha_mem_data;
    logic [255:0]   H_row;
    logic           H_row_tvalid;
    logic [127:0]   y;
    logic           y_tvalid;
    logic [31:0]    alpha_u_col;
    logic           alpha_u_col_tvalid;
    logic           alpha_u_col_tlast;
    logic [31:0]    beta;
    logic           beta_tvalid;
    logic [31:0]    beta_out;
    logic           beta_out_tvalid;
    logic [2:0]     beta_out_idx;
    logic           busy;
    logic           done;
    logic           timeout_err;

    int checks = 0;
    int errors = 0;
    int n_h, n_beat, n_last, n_bout, n_done;

    cal_core_sched #(
        .J(J), .I(I), .A(A), .TIMEOUT(TO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .h_mem_addr         (h_mem_addr),
        .h_mem_data         (h_mem_data),
        .y_mem_data         (y_mem_data),
        .alpha_mem_addr     (alpha_mem_addr),
        .alpha_mem_data     (alpha_mem_data),
        .H_row              (H_row),
        .H_row_tvalid       (H_row_tvalid),
        .y                  (y),
        .y_tvalid           (y_tvalid),
        .alpha_u_col        (alpha_u_col),
        .alpha_u_col_tvalid (alpha_u_col_tvalid),
        .alpha_u_col_tlast  (alpha_u_col_tlast),
        .beta               (beta),
        .beta_tvalid        (beta_tvalid),
        .beta_out           (beta_out),
        .beta_out_tvalid    (beta_out_tvalid),
        .beta_out_idx       (beta_out_idx),
        .busy               (busy),
        .done               (done),
        .timeout_err        (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] h_val(input int r);
        logic [7:0] b;
        b = r[7:0];
        return {4{8'hA5, 48'h0, b}};
    endfunction

    function automatic logic [127:0] y_val(input int r);
        logic [7:0] b;
        b = r[7:0];
        return {64'hDEAD_BEEF_0000_0000, 56'h0, b};
    endfunction

    function automatic logic [31:0] a_val(input int c);
        logic [7:0] b;
        b = c[7:0];
        return {8'h3C, b, 8'hC3, ~b};
    endfunction

    function automatic logic [31:0] b_val(input int r);
        logic [7:0] b;
        b = r[7:0];
        return {8'hB0, b, 8'h5A, 8'h11};
    endfunction

    // memories with one cycle of read latency
    always @(posedge clk) begin
        h_mem_data     <= h_val(int'(h_mem_addr));
        y_mem_data     <= y_val(int'(h_mem_addr));
        alpha_mem_data <= a_val(int'(alpha_mem_addr));
    end

    always @(negedge clk) begin
        if (H_row_tvalid) n_h++;
        if (alpha_u_col_tvalid) n_beat++;
        if (alpha_u_col_tvalid && alpha_u_col_tlast) n_last++;
        if (beta_out_tvalid) n_bout++;
        if (done) n_done++;
    end

    task automatic chk(input string t, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
        end
    endtask

    task automatic clr_cnt();
        n_h = 0; n_beat = 0; n_last = 0; n_bout = 0; n_done = 0;
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_ctl"}, 256'({busy, done, timeout_err, H_row_tvalid,
            y_tvalid, alpha_u_col_tvalid, alpha_u_col_tlast,
            beta_out_tvalid}), 256'(0));
        chk({t, "_hrow"}, H_row, 256'(0));
        chk({t, "_y"}, 256'(y), 256'(0));
        chk({t, "_alpha"}, 256'(alpha_u_col), 256'(0));
        chk({t, "_bout"}, 256'(beta_out), 256'(0));
        chk({t, "_addr"}, 256'({h_mem_addr, alpha_mem_addr, beta_out_idx}),
            256'(0));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 256'(busy), 256'(1));
        chk("start_tmo_clr", 256'(timeout_err), 256'(0));
    endtask

    task automatic wait_hy();
        int n;
        n = 0;
        while (!H_row_tvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hy_wait", 256'({H_row_tvalid, y_tvalid}), 256'(3));
    endtask

    // d >= 0: core answers d cycles after tlast; d < 0: no answer
    task automatic run_row(input int row, input int d,
                           input bit sp_start, input bit sp_beta);
        wait_hy();
        chk("hrow", H_row, h_val(row));
        chk("yval", 256'(y), 256'(y_val(row)));
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 4)
                chk("alpha_addr", 256'(alpha_mem_addr), 256'(row*A + k));
            chk("alpha_vld", 256'(alpha_u_col_tvalid), 256'(k >= 2));
            chk("alpha_last", 256'(alpha_u_col_tlast), 256'(k == 5));
            if (k >= 2)
                chk("alpha_data", 256'(alpha_u_col), 256'(a_val(row*A + k - 2)));
            if (k == 1)
                chk("spur_bout", 256'(beta_out_tvalid), 256'(0));
            if (k == 0) begin
                start       = sp_start;
                beta_tvalid = sp_beta;
                beta        = 32'hDEAD_DEAD;
            end else if (k == 1) begin
                start       = 1'b0;
                beta_tvalid = 1'b0;
            end
        end
        if (d >= 0) begin
            repeat (d) @(negedge clk);
            chk("wait_busy", 256'({busy, beta_out_tvalid}), 256'(2));
            beta        = b_val(row);
            beta_tvalid = 1'b1;
            @(negedge clk);
            beta_tvalid = 1'b0;
            chk("bout_vld", 256'(beta_out_tvalid), 256'(1));
            chk("bout_data", 256'(beta_out), 256'(b_val(row)));
            chk("bout_idx", 256'(beta_out_idx), 256'(row));
            chk("done_pulse", 256'(done), 256'(row == I-1));
            chk("no_tmo", 256'(timeout_err), 256'(0));
        end
    endtask

    task automatic finish_run(input string t);
        @(negedge clk);
        chk({t, "_end"}, 256'({busy, done}), 256'(0));
        chk({t, "_cnt"}, 256'({8'(n_h), 8'(n_beat), 8'(n_last),
            8'(n_bout), 8'(n_done)}), 256'({8'd8, 8'd32, 8'd8, 8'd8, 8'd1}));
    endtask

    initial begin
        rst_n       = 1'b1;
        start       = 1'b0;
        beta_tvalid = 1'b0;
        beta        = '0;
        clr_cnt();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 256'(busy), 256'(0));

        // nominal run
        do_start();
        clr_cnt();
        for (int r = 0; r < I; r++) run_row(r, 5, 1'b0, 1'b0);
        finish_run("nom");

        // spurious start and beta during row 4
        do_start();
        clr_cnt();
        for (int r = 0; r < I; r++) run_row(r, 5, r == 4, r == 4);
        finish_run("spur");

        // timeout: core never answers row 2
        do_start();
        clr_cnt();
        run_row(0, 5, 1'b0, 1'b0);
        run_row(1, 5, 1'b0, 1'b0);
        run_row(2, -1, 1'b0, 1'b0);
        repeat (TO + 1) @(negedge clk);
        chk("tmo_pre", 256'({busy, timeout_err}), 256'(2));
        @(negedge clk);
        chk("tmo_set", 256'({busy, timeout_err, done}), 256'(2));
        chk("tmo_cnt", 256'({8'(n_done), 8'(n_bout)}), 256'({8'd0, 8'd2}));
        repeat (2) @(negedge clk);
        chk("tmo_sticky", 256'({busy, timeout_err}), 256'(1));

        // tie: beta on the wait_cnt == TIMEOUT cycle
        do_start();
        clr_cnt();
        run_row(0, TO + 1, 1'b0, 1'b0);
        for (int r = 1; r < I; r++) run_row(r, 5, 1'b0, 1'b0);
        finish_run("tie");

        // reset during STREAM of row 5
        do_start();
        clr_cnt();
        for (int r = 0; r < 5; r++) run_row(r, 5, 1'b0, 1'b0);
        wait_hy();
        chk("r5_addr", 256'(alpha_mem_addr), 256'(20));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        clr_cnt();
        repeat (3) @(negedge clk);
        chk_zero("rst_hold");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_quiet", 256'({busy, 8'(n_h), 8'(n_beat), 8'(n_bout),
            8'(n_done)}), 256'(0));
        do_start();
        clr_cnt();
        for (int r = 0; r < I; r++) run_row(r, 5, 1'b0, 1'b0);
        finish_run("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cal_core_sched.md
CAL_CORE_SCHED -- requirements
Module: cal_core_sched

Interface
REQ-001 SHALL have parameter J, default 4, user count (H_row = J*64 bits, alpha column = J*8 bits).
REQ-002 SHALL have parameter I, default 8, rows per run.
REQ-003 SHALL have parameter A, default 4, alpha columns per row and beta bytes.
REQ-004 SHALL have parameter TIMEOUT, default 1023, maximum WAIT_BETA cycles before abort.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, run request; sampled only in IDLE.
REQ-008 SHALL have port h_mem_addr, output, $clog2(I), H/y memory row address.
REQ-009 SHALL have port h_mem_data, input, J*64, H row; valid 1 cycle after address.
REQ-010 SHALL have port y_mem_data, input, 128, y word at h_mem_addr; same latency.
REQ-011 SHALL have port alpha_mem_addr, output, $clog2(I*A), alpha column address.
REQ-012 SHALL have port alpha_mem_data, input, J*8, alpha column; valid 1 cycle after address.
REQ-013 SHALL have ports H_row (J*64), H_row_tvalid (1), y (128) and y_tvalid (1), outputs to the core.
REQ-014 SHALL have ports alpha_u_col (J*8), alpha_u_col_tvalid (1) and alpha_u_col_tlast (1), outputs to the core.
REQ-015 SHALL have ports beta (A*8) and beta_tvalid (1), inputs from the core.
REQ-016 SHALL have ports beta_out (A*8), beta_out_tvalid (1) and beta_out_idx ($clog2(I)), outputs carrying results tagged with the row.
REQ-017 SHALL have ports busy, done and timeout_err, all outputs of width 1, reporting status.

Function
REQ-018 SHALL implement FSM states IDLE, RD_HY, LOAD_HY, STREAM, WAIT_BETA and FIN; FIN lasts one cycle.
REQ-019 SHALL, in IDLE with start=1, clear row_cnt and timeout_err and go to RD_HY; start outside IDLE is ignored.
REQ-020 SHALL drive h_mem_addr = row_cnt combinationally in every state.
REQ-021 SHALL spend exactly 1 cycle each in RD_HY and LOAD_HY; at the end of LOAD_HY, H_row<=h_mem_data and y<=y_mem_data.
REQ-022 SHALL pulse H_row_tvalid and y_tvalid together for exactly one cycle, the first cycle of STREAM.
REQ-023 SHALL, in STREAM, drive alpha_mem_addr = row_cnt*A + col_cnt, with col_cnt stepping 0..A-1, one column per cycle.
REQ-024 SHALL register alpha_mem_data into alpha_u_col; alpha_u_col_tvalid is high A consecutive cycles starting 2 cycles after the first STREAM cycle.
REQ-025 SHALL assert alpha_u_col_tlast only with the column col_cnt=A-1.
REQ-026 SHALL enter WAIT_BETA the cycle after the last alpha_u_col_tvalid and clear wait_cnt.
REQ-027 SHALL, in WAIT_BETA with beta_tvalid=1, register beta into beta_out and pulse beta_out_tvalid for 1 cycle on the next cycle with beta_out_idx=row_cnt.
REQ-028 SHALL, on that beta_tvalid cycle, go to FIN when row_cnt=I-1; otherwise increment row_cnt and go to RD_HY.
REQ-029 SHALL pulse done in FIN, then return to IDLE.
REQ-030 SHALL increment wait_cnt every WAIT_BETA cycle without beta_tvalid.
REQ-031 SHALL, when wait_cnt reaches TIMEOUT, set timeout_err (sticky until the next accepted start) and go to IDLE without asserting done.
REQ-032 SHALL give beta_tvalid priority when it arrives on the same cycle wait_cnt=TIMEOUT: the beta is captured and the timeout is not flagged.
REQ-033 SHALL ignore beta_tvalid outside WAIT_BETA: no capture and no state change.
REQ-034 SHALL hold busy=1 in every state except IDLE.
REQ-035 SHALL never overlap an H/y load with an alpha stream: at most one row is outstanding at the core.

Reset
REQ-036 SHALL, while rst_n=0, force state=IDLE and clear row_cnt, col_cnt and wait_cnt.
REQ-037 SHALL, while rst_n=0, drive all outputs to 0: busy, done, timeout_err, every tvalid/tlast, H_row, y, alpha_u_col, beta_out, beta_out_idx and both addresses.
REQ-038 SHALL, on reset assertion mid-run, abort immediately; outputs are 0 from the asserting edge with no partial pulses afterwards, and a fresh start is required.

Verification
REQ-039 SHALL cover a nominal run (I=8, A=4): memory returns H=row, core answers beta 5 cycles after tlast -> 8 H_row_tvalid pulses, 32 alpha_u_col_tvalid beats with 8 tlasts, beta_out_idx 0..7 in order, then one done pulse, then busy=0.
REQ-040 SHALL cover addressing for row 3 -> alpha_mem_addr = 12,13,14,15 on consecutive cycles, with alpha_u_col_tvalid two cycles after address 12.
REQ-041 SHALL cover a timeout with TIMEOUT=16 and the core never answering row 2 -> timeout_err=1 after 16 WAIT_BETA cycles, state IDLE, no done; the next start clears timeout_err.
REQ-042 SHALL cover the tie case: beta_tvalid on the cycle wait_cnt=TIMEOUT -> beta captured, timeout_err=0, row advances.
REQ-043 SHALL cover spurious inputs: start pulsed at row 4 and beta_tvalid pulsed during STREAM -> both ignored; output sequence identical to the nominal run.
REQ-044 SHALL cover reset asserted during STREAM of row 5 -> all outputs 0 on the same edge; after release, start restarts from row 0.
